// File: rtl/mod_arith_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mod_arith_arb_pkg
// Brief    : Shared types and helpers for the mod-P arithmetic arbiter:
//            arbiter state encoding, id-width calculation, ctl id-field
//            insert/extract and round-robin index stepping.
// Revision : 1.0 - initial release
// ============================================================================
package mod_arith_arb_pkg;

  // Widest ctl word and id field the helpers handle; callers size-cast.
  localparam int c_ctl_max = 64;
  localparam int c_id_max  = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  // Width of the requester index, never less than one bit.
  function automatic int id_bits(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Next index in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  // Overwrite ctl[lsb +: bits] with the low bits of id.
  function automatic logic [c_ctl_max-1:0] ctl_set_id(
    input logic [c_ctl_max-1:0] ctl,
    input logic [c_id_max-1:0]  id,
    input int                   lsb,
    input int                   bits
  );
    logic [c_ctl_max-1:0] r;
    r = ctl;
    for (int i = 0; i < bits; i++) begin
      r[lsb+i] = id[i];
    end
    return r;
  endfunction

  // Extract ctl[lsb +: bits] as a zero-extended id.
  function automatic logic [c_id_max-1:0] ctl_get_id(
    input logic [c_ctl_max-1:0] ctl,
    input int                   lsb,
    input int                   bits
  );
    logic [c_id_max-1:0] r;
    r = '0;
    for (int i = 0; i < bits; i++) begin
      r[i] = ctl[lsb+i];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_arith_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker. Searches i_req starting at
//            the entry after i_last and reports the first one set.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import mod_arith_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_BITS = id_bits(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_BITS-1:0] i_last,
  output logic               o_val,
  output logic [ID_BITS-1:0] o_idx
);

  // Walk the ring once from last+1; the first hit wins.
  always_comb begin
    int                 k;
    logic [ID_BITS-1:0] w_k;
    o_val = 1'b0;
    o_idx = '0;
    k     = int'(i_last);
    w_k   = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      k   = rr_next(k, NUM_REQ);
      w_k = ID_BITS'(k);
      if (!o_val && i_req[w_k]) begin
        o_val = 1'b1;
        o_idx = w_k;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mod_arith_arb.sv
`default_nettype none
// ============================================================================
// Module   : mod_arith_arb
// Brief    : Packet-level round-robin arbiter sharing one mod-P arithmetic
//            unit between NUM_REQ requesters. The granted requester index is
//            stamped into ctl[ID_LSB +: ID_BITS]; results are steered back
//            by decoding that field. Build option MOD_ARITH_ARB_STATS_EN adds
//            per-requester saturating packet counters on o_pkt_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module mod_arith_arb
  import mod_arith_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DAT_BITS = 128,
  parameter int RES_BITS = 64,
  parameter int CTL_BITS = 16,
  parameter int ID_LSB   = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_REQ-1:0]           i_req_val,
  input  logic [NUM_REQ-1:0]           i_req_sop,
  input  logic [NUM_REQ-1:0]           i_req_eop,
  input  logic [NUM_REQ*DAT_BITS-1:0]  i_req_dat,
  input  logic [NUM_REQ*CTL_BITS-1:0]  i_req_ctl,
  output logic [NUM_REQ-1:0]           o_req_rdy,
  output logic                         o_arb_val,
  output logic                         o_arb_sop,
  output logic                         o_arb_eop,
  output logic [DAT_BITS-1:0]          o_arb_dat,
  output logic [CTL_BITS-1:0]          o_arb_ctl,
  input  logic                         i_arb_rdy,
  input  logic                         i_res_val,
  input  logic                         i_res_sop,
  input  logic                         i_res_eop,
  input  logic [RES_BITS-1:0]          i_res_dat,
  input  logic [CTL_BITS-1:0]          i_res_ctl,
  output logic                         o_res_rdy,
  output logic [NUM_REQ-1:0]           o_rsp_val,
  output logic [NUM_REQ-1:0]           o_rsp_sop,
  output logic [NUM_REQ-1:0]           o_rsp_eop,
  output logic [NUM_REQ*RES_BITS-1:0]  o_rsp_dat,
  output logic [NUM_REQ*CTL_BITS-1:0]  o_rsp_ctl,
  input  logic [NUM_REQ-1:0]           i_rsp_rdy
`ifdef MOD_ARITH_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]        o_pkt_cnt
`endif
);

  localparam int ID_BITS = id_bits(NUM_REQ);

  arb_state_t          r_state;
  logic [ID_BITS-1:0]  r_gnt;
  logic [ID_BITS-1:0]  r_last;
  logic                w_pick_val;
  logic [ID_BITS-1:0]  w_pick_idx;
  logic                w_gnt_rdy;
  logic                w_acc;
  logic [CTL_BITS-1:0] w_gnt_ctl;
  logic [ID_BITS-1:0]  w_res_id;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_BITS (ID_BITS)
  ) u_rr_pick (
    .i_req  (i_req_val),
    .i_last (r_last),
    .o_val  (w_pick_val),
    .o_idx  (w_pick_idx)
  );

  // The output slot is free when empty or being drained this cycle.
  assign w_gnt_rdy = ~o_arb_val | i_arb_rdy;
  assign w_acc     = (r_state == ST_LOCK) & i_req_val[r_gnt] & w_gnt_rdy;
  assign w_gnt_ctl = CTL_BITS'(ctl_set_id(
                       c_ctl_max'(i_req_ctl[int'(r_gnt)*CTL_BITS +: CTL_BITS]),
                       c_id_max'(r_gnt), ID_LSB, ID_BITS));

  // Only the granted requester sees ready, and never during reset.
  always_comb begin
    o_req_rdy = '0;
    if (r_state == ST_LOCK && !i_rst) begin
      o_req_rdy[r_gnt] = w_gnt_rdy;
    end
  end

  // Grant FSM and the registered output stage toward the shared unit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_last    <= ID_BITS'(NUM_REQ - 1);
      o_arb_val <= 1'b0;
      o_arb_sop <= 1'b0;
      o_arb_eop <= 1'b0;
      o_arb_dat <= '0;
      o_arb_ctl <= '0;
    end else begin
      if (i_arb_rdy) begin
        o_arb_val <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_pick_val) begin
            r_gnt   <= w_pick_idx;
            r_state <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (w_acc) begin
            o_arb_val <= 1'b1;
            o_arb_sop <= i_req_sop[r_gnt];
            o_arb_eop <= i_req_eop[r_gnt];
            o_arb_dat <= i_req_dat[int'(r_gnt)*DAT_BITS +: DAT_BITS];
            o_arb_ctl <= w_gnt_ctl;
            if (i_req_eop[r_gnt]) begin
              r_last  <= r_gnt;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Result steering: decode the id field; ids past NUM_REQ are dropped.
  assign w_res_id = ID_BITS'(ctl_get_id(c_ctl_max'(i_res_ctl), ID_LSB, ID_BITS));

  // Route valid/ready to the addressed requester only.
  always_comb begin
    o_rsp_val = '0;
    o_res_rdy = 1'b1;
    if (int'(w_res_id) < NUM_REQ) begin
      o_rsp_val[w_res_id] = i_res_val;
      o_res_rdy           = i_rsp_rdy[w_res_id];
    end
  end

  assign o_rsp_sop = {NUM_REQ{i_res_sop}};
  assign o_rsp_eop = {NUM_REQ{i_res_eop}};
  assign o_rsp_dat = {NUM_REQ{i_res_dat}};
  assign o_rsp_ctl = {NUM_REQ{i_res_ctl}};

`ifdef MOD_ARITH_ARB_STATS_EN
  logic [15:0] r_pkt_cnt [NUM_REQ];

  // Count accepted eop words per requester, saturating at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_pkt_cnt[i] <= '0;
      end
    end else if (w_acc && i_req_eop[r_gnt] && r_pkt_cnt[r_gnt] != 16'hFFFF) begin
      r_pkt_cnt[r_gnt] <= r_pkt_cnt[r_gnt] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pkt_cnt
    assign o_pkt_cnt[g*16 +: 16] = r_pkt_cnt[g];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_arith_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_arith_arb
// Brief    : Directed self-checking bench for mod_arith_arb (NUM_REQ=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_arith_arb;

  localparam int NR = 4;
  localparam int DB = 128;
  localparam int RB = 64;
  localparam int CB = 16;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [NR-1:0]     i_req_val = '0;
  logic [NR-1:0]     i_req_sop = '0;
  logic [NR-1:0]     i_req_eop = '0;
  logic [NR*DB-1:0]  i_req_dat = '0;
  logic [NR*CB-1:0]  i_req_ctl = '0;
  logic [NR-1:0]     o_req_rdy;
  logic              o_arb_val, o_arb_sop, o_arb_eop;
  logic [DB-1:0]     o_arb_dat;
  logic [CB-1:0]     o_arb_ctl;
  logic              i_arb_rdy = 1'b0;
  logic              i_res_val = 1'b0;
  logic              i_res_sop = 1'b0;
  logic              i_res_eop = 1'b0;
  logic [RB-1:0]     i_res_dat = '0;
  logic [CB-1:0]     i_res_ctl = '0;
  logic              o_res_rdy;
  logic [NR-1:0]     o_rsp_val, o_rsp_sop, o_rsp_eop;
  logic [NR*RB-1:0]  o_rsp_dat;
  logic [NR*CB-1:0]  o_rsp_ctl;
  logic [NR-1:0]     i_rsp_rdy = '0;
`ifdef MOD_ARITH_ARB_STATS_EN
  logic [NR*16-1:0]  o_pkt_cnt;
`endif

  always #5 i_clk = ~i_clk;

  mod_arith_arb dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_req_val (i_req_val),
    .i_req_sop (i_req_sop),
    .i_req_eop (i_req_eop),
    .i_req_dat (i_req_dat),
    .i_req_ctl (i_req_ctl),
    .o_req_rdy (o_req_rdy),
    .o_arb_val (o_arb_val),
    .o_arb_sop (o_arb_sop),
    .o_arb_eop (o_arb_eop),
    .o_arb_dat (o_arb_dat),
    .o_arb_ctl (o_arb_ctl),
    .i_arb_rdy (i_arb_rdy),
    .i_res_val (i_res_val),
    .i_res_sop (i_res_sop),
    .i_res_eop (i_res_eop),
    .i_res_dat (i_res_dat),
    .i_res_ctl (i_res_ctl),
    .o_res_rdy (o_res_rdy),
    .o_rsp_val (o_rsp_val),
    .o_rsp_sop (o_rsp_sop),
    .o_rsp_eop (o_rsp_eop),
    .o_rsp_dat (o_rsp_dat),
    .o_rsp_ctl (o_rsp_ctl),
    .i_rsp_rdy (i_rsp_rdy)
`ifdef MOD_ARITH_ARB_STATS_EN
    ,
    .o_pkt_cnt (o_pkt_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Requester model state
  int            ptr [NR];
  int            nw  [NR];
  int            plen;
  int            rdy_mode;
  int            cyc;
  int            acc_cyc;
  int            val_cyc;
  logic [NR-1:0] acc_mask;
  logic          prev_stall;
  logic [DB-1:0] prev_dat;
  logic [CB-1:0] prev_ctl;

  // Captured words leaving toward the shared unit, and the expected order
  logic [DB-1:0] g_dat [$];
  logic [CB-1:0] g_ctl [$];
  logic          g_sop [$];
  logic          g_eop [$];
  int            e_r   [$];
  int            e_w   [$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DB-1:0] mk_dat(input int r, input int w);
    return {32'hDA7A_0000 | 32'(r), 32'(w), 32'h5EED_0000 | 32'(r), 32'(w)};
  endfunction

  // Requesters put 2'b11 in the id field; the arbiter must overwrite it.
  function automatic logic [CB-1:0] mk_ctl(input int w);
    return {8'hA3, 8'(w)};
  endfunction

  function automatic logic [CB-1:0] exp_ctl(input int r, input int w);
    return {6'b101000, 2'(r), 8'(w)};
  endfunction

  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      i_req_val[r]            = (ptr[r] < nw[r]);
      i_req_sop[r]            = ((ptr[r] % plen) == 0);
      i_req_eop[r]            = ((ptr[r] % plen) == plen - 1);
      i_req_dat[r*DB +: DB]   = mk_dat(r, ptr[r]);
      i_req_ctl[r*CB +: CB]   = mk_ctl(ptr[r]);
    end
    i_arb_rdy = (rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
  endtask

  task automatic observe();
    acc_mask = i_req_val & o_req_rdy;
    if (acc_mask != '0 && acc_cyc < 0) acc_cyc = cyc;
    if (o_arb_val && val_cyc < 0) val_cyc = cyc;
    chk("rdy_onehot", 128'($countones(o_req_rdy) <= 1), 128'(1));
    if (prev_stall) begin
      chk("stall_val", 128'(o_arb_val), 128'(1));
      chk("stall_dat", o_arb_dat, prev_dat);
      chk("stall_ctl", 128'(o_arb_ctl), 128'(prev_ctl));
    end
    prev_stall = o_arb_val && !i_arb_rdy;
    prev_dat   = o_arb_dat;
    prev_ctl   = o_arb_ctl;
    if (o_arb_val && i_arb_rdy) begin
      g_dat.push_back(o_arb_dat);
      g_ctl.push_back(o_arb_ctl);
      g_sop.push_back(o_arb_sop);
      g_eop.push_back(o_arb_eop);
    end
  endtask

  task automatic run(input int n);
    drive();
    repeat (n) begin
      @(negedge i_clk);
      cyc++;
      observe();
      @(posedge i_clk);
      #1;
      for (int r = 0; r < NR; r++) if (acc_mask[r]) ptr[r]++;
      drive();
    end
  endtask

  task automatic setup(input int pl, input int n0, input int n1, input int n2,
                       input int n3, input int rm);
    for (int r = 0; r < NR; r++) ptr[r] = 0;
    nw[0] = n0; nw[1] = n1; nw[2] = n2; nw[3] = n3;
    plen = pl; rdy_mode = rm; cyc = 0;
    acc_cyc = -1; val_cyc = -1; acc_mask = '0; prev_stall = 1'b0;
    g_dat.delete(); g_ctl.delete(); g_sop.delete(); g_eop.delete();
    e_r.delete(); e_w.delete();
  endtask

  task automatic expect_word(input int r, input int w);
    e_r.push_back(r);
    e_w.push_back(w);
  endtask

  task automatic check_seq(input string tag);
    int n;
    chk({tag, "_count"}, 128'(g_dat.size()), 128'(e_r.size()));
    n = (g_dat.size() < e_r.size()) ? g_dat.size() : e_r.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_dat"}, g_dat[i], mk_dat(e_r[i], e_w[i]));
      chk({tag, "_ctl"}, 128'(g_ctl[i]), 128'(exp_ctl(e_r[i], e_w[i])));
      chk({tag, "_sop"}, 128'(g_sop[i]), 128'((e_w[i] % plen) == 0));
      chk({tag, "_eop"}, 128'(g_eop[i]), 128'((e_w[i] % plen) == plen - 1));
    end
  endtask

  task automatic do_reset();
    i_rst     = 1'b1;
    i_req_val = '0;
    i_arb_rdy = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with every requester asking
    i_req_val = '1;
    @(negedge i_clk);
    chk("rst_arb_val", 128'(o_arb_val), 128'(0));
    chk("rst_arb_sop", 128'(o_arb_sop), 128'(0));
    chk("rst_arb_eop", 128'(o_arb_eop), 128'(0));
    chk("rst_arb_dat", o_arb_dat, 128'(0));
    chk("rst_arb_ctl", 128'(o_arb_ctl), 128'(0));
    chk("rst_req_rdy", 128'(o_req_rdy), 128'(0));
    i_req_val = '0;
    i_rst     = 1'b0;

    // Requester 2 alone, one 2-word packet, unit always ready
    setup(2, 0, 0, 2, 0, 0);
    expect_word(2, 0); expect_word(2, 1);
    run(10);
    check_seq("t1");
    chk("t1_latency", 128'(val_cyc - acc_cyc), 128'(1));

    // Result path: id 2 steered to slot 2 only, broadcast data/ctl
    @(posedge i_clk); #1;
    i_res_val = 1'b1; i_res_sop = 1'b1; i_res_eop = 1'b1;
    i_res_ctl = 16'h0255; i_res_dat = 64'hDEAD_BEEF_0000_0002;
    i_rsp_rdy = 4'b0100;
    #1;
    chk("r_val_id2", 128'(o_rsp_val), 128'(4'b0100));
    chk("r_rdy_id2", 128'(o_res_rdy), 128'(1));
    chk("r_dat_slot2", 128'(o_rsp_dat[2*RB +: RB]), 128'(64'hDEAD_BEEF_0000_0002));
    chk("r_ctl_slot0", 128'(o_rsp_ctl[0 +: CB]), 128'(16'h0255));
    chk("r_sop_bcast", 128'(o_rsp_sop), 128'(4'hF));
    i_rsp_rdy = 4'b1011;
    #1;
    chk("r_rdy_id2_low", 128'(o_res_rdy), 128'(0));
    i_res_ctl = 16'h0300;
    #1;
    chk("r_val_id3", 128'(o_rsp_val), 128'(4'b1000));
    chk("r_rdy_id3", 128'(o_res_rdy), 128'(1));
    i_res_val = 1'b0;
    #1;
    chk("r_val_idle", 128'(o_rsp_val), 128'(0));

    // All four requesters: grant order 0,1,2,3,0, whole packets
    do_reset();
    setup(2, 4, 2, 2, 2, 0);
    expect_word(0, 0); expect_word(0, 1);
    expect_word(1, 0); expect_word(1, 1);
    expect_word(2, 0); expect_word(2, 1);
    expect_word(3, 0); expect_word(3, 1);
    expect_word(0, 2); expect_word(0, 3);
    run(40);
    check_seq("t2");

    // Unit ready toggling: stalls hold data, each word once, in order
    do_reset();
    setup(2, 4, 2, 0, 0, 1);
    expect_word(0, 0); expect_word(0, 1);
    expect_word(1, 0); expect_word(1, 1);
    expect_word(0, 2); expect_word(0, 3);
    run(60);
    check_seq("t3");

    // Result for id 1 blocked 5 cycles while requester 3 streams
    do_reset();
    setup(2, 0, 0, 0, 4, 0);
    expect_word(3, 0); expect_word(3, 1); expect_word(3, 2); expect_word(3, 3);
    fork
      run(30);
      begin
        @(posedge i_clk); #1;
        i_res_val = 1'b1; i_res_ctl = 16'h0100; i_res_dat = 64'h1111;
        i_rsp_rdy = 4'b1101;
        repeat (5) begin
          @(negedge i_clk);
          chk("t4_res_rdy_blk", 128'(o_res_rdy), 128'(0));
          chk("t4_rsp_val", 128'(o_rsp_val), 128'(4'b0010));
        end
        @(posedge i_clk); #1;
        i_rsp_rdy = 4'b1111;
        @(negedge i_clk);
        chk("t4_res_rdy_go", 128'(o_res_rdy), 128'(1));
        @(posedge i_clk); #1;
        i_res_val = 1'b0;
      end
    join
    check_seq("t4");

    // Asynchronous reset mid-packet, then requester 0 wins first
    do_reset();
    setup(4, 0, 4, 0, 0, 0);
    run(4);
    chk("t5_pre_val", 128'(o_arb_val), 128'(1));
    #2;
    i_rst = 1'b1;
    #1;
    chk("t5_async_val", 128'(o_arb_val), 128'(0));
    chk("t5_async_rdy", 128'(o_req_rdy), 128'(0));
    @(negedge i_clk);
    setup(2, 2, 2, 0, 2, 0);
    expect_word(0, 0); expect_word(0, 1);
    expect_word(1, 0); expect_word(1, 1);
    expect_word(3, 0); expect_word(3, 1);
    i_rst = 1'b0;
    run(30);
    check_seq("t5");

`ifdef MOD_ARITH_ARB_STATS_EN
    // Three packets from requester 1
    do_reset();
    setup(2, 0, 6, 0, 0, 0);
    run(30);
    chk("st_cnt1", 128'(o_pkt_cnt[31:16]), 128'(3));
    chk("st_cnt0", 128'(o_pkt_cnt[15:0]), 128'(0));
    chk("st_cnt2", 128'(o_pkt_cnt[47:32]), 128'(0));
    chk("st_cnt3", 128'(o_pkt_cnt[63:48]), 128'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
